bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-port arbiter that shares the single-port on-chip BRAM between the instruction-fetch and data-memory interfaces of the core. Requests arrive as one-cycle valid pulses, are held until granted, and are scheduled round-robin onto the BRAM port. Each grant produces exactly one ready pulse on the originating port. The block sits between the core's memory ports and the BRAM macro. It is instantiated only when the shared-BRAM memory map is used, with itim and dtim disabled.

## Interface
- `bram_depth`, default 11: BRAM word-address width (2^11 32-bit words = 8 KiB).
- `bram_base_addr`, default 32'h0: first byte address served.
- `bram_top_addr`, default 32'h2000: first byte address not served (exclusive).
- `reset` in 1: synchronous, active-low reset.
- `clock` in 1: single clock; all state updates on the rising edge.
- `imem_valid` in 1: instruction read request pulse.
- `imem_addr` in 32: instruction byte address.
- `imem_ready` out 1: response pulse for instruction port.
- `imem_rdata` out 32: instruction read data, valid with `imem_ready`.
- `imem_error` out 1: access was out of range, valid with `imem_ready`.
- `dmem_valid` in 1: data request pulse.
- `dmem_addr` in 32: data byte address.
- `dmem_wdata` in 32: write data.
- `dmem_wstrb` in 4: byte write enables; 0 means read.
- `dmem_ready` out 1: response pulse for data port.
- `dmem_rdata` out 32: data read data, valid with `dmem_ready`.
- `dmem_error` out 1: access was out of range, valid with `dmem_ready`.
- `bram_en` out 1: BRAM access enable.
- `bram_we` out 4: BRAM byte write enables.
- `bram_addr` out bram_depth: BRAM word address.
- `bram_wdata` out 32: BRAM write data.
- `bram_rdata` in 32: BRAM read data, registered inside the BRAM, one cycle after `bram_en`.

## Operation
- **Per-port pending register.** Each port holds pending flag, address, and (data port) wdata/wstrb. A request is captured on valid when no request of that port is pending or in flight.
  - valid while a request is pending or in flight: ignored. Protocol forbids it.
  - valid in the same cycle as that port's ready pulse: accepted.
- **Candidate set.** A port is a candidate if its valid is high this cycle or its pending flag is set. A valid request is eligible for grant in the same cycle it arrives.
- **Arbitration.**
  - One candidate: it is granted.
  - Two candidates: the port not granted last wins.
  - `last_grant` pointer updates only on a grant; reset value is data, so instruction wins the first conflict.
  - The loser stays pending and is granted the next cycle. Maximum wait is 1 cycle.
- **Range check.** Address is in range iff `bram_base_addr <= addr < bram_top_addr`.
  - In range: `bram_en`=1, `bram_addr`=(addr−bram_base_addr)[bram_depth+1:2], `bram_we`=wstrb (instruction port: 0), `bram_wdata`=wdata. addr[1:0] is ignored.
  - Out of range: BRAM not enabled. Grant still consumes the slot and the response carries error=1, rdata=0.
- **Response stage.** One register holds {valid, port, error} for the access issued last cycle.
  - Next cycle it pulses the port's ready.
  - rdata = `bram_rdata` for an in-range read, 0 for an error or write.
  - The other port's rdata is driven 0.
- **Reset.** Clears pending flags, the response stage, and `last_grant`=data. A mid-operation reset drops in-flight requests with no ready issued.

## Timing
- Reset values: all ready/error/rdata outputs 0; `bram_en`=0, `bram_we`=0, `bram_addr`=0, `bram_wdata`=0.
- BRAM outputs are combinational from the grant. Ready/error/rdata come from the response register plus `bram_rdata`.
- Uncontested latency: valid at cycle N → ready at N+1.
- Contested loser: ready at N+2.
- Throughput: one access per cycle; both ports saturated alternate I, D, I, D.
- Ready is exactly one cycle wide; at most one port has ready high per cycle.

## Structure
- Shared package: address-range constants (`bram_base_addr`, `bram_top_addr`, `bram_depth`) plus a `mem_req` struct {valid, addr, wdata, wstrb} and a `mem_resp` struct {ready, rdata, error}, reused by other memory slaves.
- One natural sub-module: `rr_arbiter2`, a 2-requester round-robin with a `last_grant` register, producing a one-hot grant.

## Test plan
- **Single read.** After reset, preload word 5 = 32'hDEADBEEF; imem_valid, addr 32'h14 at cycle 0 → `bram_en`=1, `bram_addr`=5 at cycle 0; `imem_ready`=1, `imem_rdata`=32'hDEADBEEF at cycle 1.
- **Simultaneous requests.** imem addr 32'h0 and dmem read 32'h1000 in the same cycle → instruction granted first (ready cycle 1), data ready at cycle 2. Repeat the conflict: data wins.
- **Byte write then read.** dmem write addr 32'h8, wdata 32'h11223344, wstrb 4'b0010 over 32'h0 → `bram_we`=4'b0010, ready at +1; subsequent read returns 32'h00003300.
- **Out of range.** dmem read 32'h2000 → `bram_en` stays 0; `dmem_ready`=1, `dmem_error`=1, rdata 0 one cycle later. Addr 32'h1FFC → normal access.
- **Back-to-back saturation.** Both ports re-pulse valid on every ready for 20 cycles → grants alternate strictly, no lost or duplicated ready, each port gets 10.
- **Reset mid-operation.** Assert reset the cycle after a contested conflict → loser never receives ready; all outputs 0 in the following cycle.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// Shared memory-slave definitions: BRAM address window, request/response structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   def_bram_depth / def_bram_base_addr / def_bram_top_addr : default BRAM window
//   port_e        : requester identity (instruction / data)
//   mem_req       : {valid, addr, wdata, wstrb}
//   mem_resp      : {ready, rdata, error}
//   addr_in_range : base <= addr < top
package bram_arbiter_pkg;

  localparam int unsigned def_bram_depth     = 11;
  localparam logic [31:0] def_bram_base_addr = 32'h0000_0000;
  localparam logic [31:0] def_bram_top_addr  = 32'h0000_2000;

  typedef enum logic {
    port_imem = 1'b0,
    port_dmem = 1'b1
  } port_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } mem_resp;

  // Top bound is exclusive.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/bram_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// Latency: grant is combinational from req; last_grant updates on the clock edge.
// Backpressure: a losing requester simply keeps req high and wins the next cycle.
//
// Ports:
//   clock, reset (sync, active-low)
//   req[1:0]   : bit 0 = instruction port, bit 1 = data port
//   grant[1:0] : one-hot, zero when no request
module rr_arbiter2
  import bram_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  port_e last_grant;

  // On a conflict the port that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (last_grant == port_dmem) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Reset to data so the instruction port wins the first conflict.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= port_dmem;
    end else if (|req) begin
      last_grant <= grant[1] ? port_dmem : port_imem;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between the instruction-fetch and data ports, round-robin.
// Latency: uncontested request valid at N -> ready at N+1; contested loser -> N+2.
// Backpressure: a losing request is held in a per-port pending register (max 1 cycle wait).
//
// Ports:
//   clock, reset (sync, active-low)
//   imem_valid/addr -> imem_ready/rdata/error   : instruction read port
//   dmem_valid/addr/wdata/wstrb -> dmem_ready/rdata/error : data port (wstrb 0 = read)
//   bram_en/we/addr/wdata -> BRAM, bram_rdata <- BRAM (registered, 1 cycle after en)
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned bram_depth     = def_bram_depth,
  parameter logic [31:0] bram_base_addr = def_bram_base_addr,
  parameter logic [31:0] bram_top_addr  = def_bram_top_addr
) (
  input  logic                  reset,
  input  logic                  clock,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_addr,
  output logic                  imem_ready,
  output logic [31:0]           imem_rdata,
  output logic                  imem_error,
  input  logic                  dmem_valid,
  input  logic [31:0]           dmem_addr,
  input  logic [31:0]           dmem_wdata,
  input  logic [3:0]            dmem_wstrb,
  output logic                  dmem_ready,
  output logic [31:0]           dmem_rdata,
  output logic                  dmem_error,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [bram_depth-1:0] bram_addr,
  output logic [31:0]           bram_wdata,
  input  logic [31:0]           bram_rdata
);

  mem_req ireq_in, dreq_in;   // live request this cycle
  mem_req ireq_q, dreq_q;     // pending (lost arbitration) request
  mem_req ireq, dreq, sel;    // effective candidate per port, and the granted one

  logic [1:0]  req, grant;
  logic        access, in_rng, en;
  logic [31:0] offset;

  port_e       rsp_port;
  logic        rsp_vld, rsp_err, rsp_rd;
  logic [31:0] rd_data;
  mem_resp     irsp, drsp;

  assign ireq_in = '{valid: imem_valid, addr: imem_addr, wdata: 32'h0, wstrb: 4'h0};
  assign dreq_in = '{valid: dmem_valid, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

  // A pending request takes priority over the live inputs; a new valid while
  // pending is a protocol violation and is dropped.
  assign ireq = ireq_q.valid ? ireq_q : ireq_in;
  assign dreq = dreq_q.valid ? dreq_q : dreq_in;

  // No grants while reset is asserted so the BRAM is never touched during reset.
  assign req = {dreq.valid, ireq.valid} & {2{reset}};

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign sel    = grant[1] ? dreq : ireq;
  assign access = |grant;
  assign in_rng = addr_in_range(sel.addr, bram_base_addr, bram_top_addr);
  assign en     = access && in_rng;
  assign offset = sel.addr - bram_base_addr;

  // Out-of-range grants still use the slot but leave the BRAM idle.
  assign bram_en    = en;
  assign bram_we    = en ? sel.wstrb : 4'h0;
  assign bram_addr  = en ? offset[bram_depth+1:2] : '0;
  assign bram_wdata = en ? sel.wdata : 32'h0;

  // Byte-lane bits and the high offset bits beyond the BRAM window are don't-care.
  logic unused_bits;
  assign unused_bits = ^{offset[31:bram_depth+2], offset[1:0], sel.valid};

  always_ff @(posedge clock) begin
    if (!reset) begin
      ireq_q <= '0;
      dreq_q <= '0;
    end else begin
      if (grant[0]) begin
        ireq_q.valid <= 1'b0;
      end else if (imem_valid && !ireq_q.valid) begin
        ireq_q <= ireq_in;
      end
      if (grant[1]) begin
        dreq_q.valid <= 1'b0;
      end else if (dmem_valid && !dreq_q.valid) begin
        dreq_q <= dreq_in;
      end
    end
  end

  // Response stage: describes the access issued in the previous cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_vld  <= 1'b0;
      rsp_port <= port_imem;
      rsp_err  <= 1'b0;
      rsp_rd   <= 1'b0;
    end else begin
      rsp_vld  <= access;
      rsp_port <= grant[1] ? port_dmem : port_imem;
      rsp_err  <= access && !in_rng;
      rsp_rd   <= en && (sel.wstrb == 4'h0);
    end
  end

  // BRAM data only passes through for an in-range read; writes and errors return 0.
  assign rd_data = rsp_rd ? bram_rdata : 32'h0;

  always_comb begin
    irsp = '0;
    drsp = '0;
    if (rsp_vld) begin
      if (rsp_port == port_dmem) begin
        drsp = '{ready: 1'b1, rdata: rd_data, error: rsp_err};
      end else begin
        irsp = '{ready: 1'b1, rdata: rd_data, error: rsp_err};
      end
    end
  end

  assign imem_ready = irsp.ready;
  assign imem_rdata = irsp.rdata;
  assign imem_error = irsp.error;
  assign dmem_ready = drsp.ready;
  assign dmem_rdata = drsp.rdata;
  assign dmem_error = drsp.error;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: per-cycle vector table plus saturation and mid-op reset sequences.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a (directed stimulus, BRAM modelled with a one-cycle registered read).
module tb_bram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [10:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;

  logic        mem_clr;
  logic [31:0] mem [0:2047];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bram_arbiter dut (
    .reset      (reset),
    .clock      (clock),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_error (imem_error),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_error (dmem_error),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  // BRAM model: byte-write, registered read (old data on read-during-write).
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
      bram_rdata <= 32'h0;
    end else if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
      bram_rdata <= mem[bram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},    bram_en,    0);
    chk({tag, "_we"},    bram_we,    0);
    chk({tag, "_baddr"}, bram_addr,  0);
    chk({tag, "_bwd"},   bram_wdata, 0);
    chk({tag, "_irdy"},  imem_ready, 0);
    chk({tag, "_ird"},   imem_rdata, 0);
    chk({tag, "_ierr"},  imem_error, 0);
    chk({tag, "_drdy"},  dmem_ready, 0);
    chk({tag, "_drd"},   dmem_rdata, 0);
    chk({tag, "_derr"},  dmem_error, 0);
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_addr = 32'h0;
    dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_zero("rst");
    @(posedge clock); #1;
    reset = 1'b1;
    mem_clr = 1'b0;
  endtask

  // One record per cycle: inputs for the cycle and every output expected in it.
  typedef struct {
    logic        iv; logic [31:0] ia;
    logic        dv; logic [31:0] da; logic [31:0] dw; logic [3:0] ds;
    logic        en; logic [3:0] we; logic [10:0] ba; logic [31:0] bw;
    logic        ir; logic [31:0] ird; logic ie;
    logic        dr; logic [31:0] drd; logic de;
  } vec_t;

  vec_t tbl [17];

  int ni, nd;

  initial begin
    reset   = 1'b0;
    mem_clr = 1'b1;
    idle_inputs();

    //           iv   ia            dv   da            dw            ds       en   we       ba       bw            ir   ird           ie   dr   drd           de
    tbl[0]  = '{1'b0, 32'h0,       1'b1, 32'h14,      32'hDEADBEEF, 4'hF,   1'b1, 4'hF,   11'h5,   32'hDEADBEEF, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0};
    tbl[1]  = '{1'b1, 32'h14,      1'b0, 32'h0,       32'h0,        4'h0,   1'b1, 4'h0,   11'h5,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0};
    tbl[2]  = '{1'b0, 32'h0,       1'b1, 32'h0,       32'hA5A50001, 4'hF,   1'b1, 4'hF,   11'h0,   32'hA5A50001, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,      1'b0};
    tbl[3]  = '{1'b0, 32'h0,       1'b1, 32'h1000,    32'h0BADF00D, 4'hF,   1'b1, 4'hF,   11'h400, 32'h0BADF00D, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0};
    // first conflict: instruction wins
    tbl[4]  = '{1'b1, 32'h0,       1'b1, 32'h1000,    32'h0,        4'h0,   1'b1, 4'h0,   11'h0,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0};
    tbl[5]  = '{1'b0, 32'h0,       1'b0, 32'h0,       32'h0,        4'h0,   1'b1, 4'h0,   11'h400, 32'h0,        1'b1, 32'hA5A50001, 1'b0, 1'b0, 32'h0,      1'b0};
    tbl[6]  = '{1'b1, 32'h1000,    1'b0, 32'h0,       32'h0,        4'h0,   1'b1, 4'h0,   11'h400, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0BADF00D, 1'b0};
    // second conflict after an instruction grant: data wins
    tbl[7]  = '{1'b1, 32'h14,      1'b1, 32'h0,       32'h0,        4'h0,   1'b1, 4'h0,   11'h0,   32'h0,        1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0,      1'b0};
    tbl[8]  = '{1'b0, 32'h0,       1'b0, 32'h0,       32'h0,        4'h0,   1'b1, 4'h0,   11'h5,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'hA5A50001, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,       1'b1, 32'h8,       32'h11223344, 4'b0010, 1'b1, 4'b0010, 11'h2, 32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,      1'b0};
    tbl[10] = '{1'b0, 32'h0,       1'b1, 32'h8,       32'h0,        4'h0,   1'b1, 4'h0,   11'h2,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0};
    tbl[11] = '{1'b0, 32'h0,       1'b1, 32'h2000,    32'h0,        4'h0,   1'b0, 4'h0,   11'h0,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h00003300, 1'b0};
    tbl[12] = '{1'b0, 32'h0,       1'b1, 32'h1FFC,    32'h0,        4'h0,   1'b1, 4'h0,   11'h7FF, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b1};
    tbl[13] = '{1'b1, 32'h2000,    1'b0, 32'h0,       32'h0,        4'h0,   1'b0, 4'h0,   11'h0,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0};
    tbl[14] = '{1'b0, 32'h0,       1'b0, 32'h0,       32'h0,        4'h0,   1'b0, 4'h0,   11'h0,   32'h0,        1'b1, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0};
    tbl[15] = '{1'b0, 32'h0,       1'b1, 32'h2004,    32'hFFFFFFFF, 4'hF,   1'b0, 4'h0,   11'h0,   32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0};
    tbl[16] = '{1'b0, 32'h0,       1'b0, 32'h0,       32'h0,        4'h0,   1'b0, 4'h0,   11'h0,   32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b1};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      @(posedge clock); #1;
      imem_valid = tbl[i].iv; imem_addr = tbl[i].ia;
      dmem_valid = tbl[i].dv; dmem_addr = tbl[i].da;
      dmem_wdata = tbl[i].dw; dmem_wstrb = tbl[i].ds;
      @(negedge clock);
      chk($sformatf("v%0d_en", i),    bram_en,    tbl[i].en);
      chk($sformatf("v%0d_we", i),    bram_we,    tbl[i].we);
      chk($sformatf("v%0d_baddr", i), bram_addr,  tbl[i].ba);
      chk($sformatf("v%0d_bwd", i),   bram_wdata, tbl[i].bw);
      chk($sformatf("v%0d_irdy", i),  imem_ready, tbl[i].ir);
      chk($sformatf("v%0d_ird", i),   imem_rdata, tbl[i].ird);
      chk($sformatf("v%0d_ierr", i),  imem_error, tbl[i].ie);
      chk($sformatf("v%0d_drdy", i),  dmem_ready, tbl[i].dr);
      chk($sformatf("v%0d_drd", i),   dmem_rdata, tbl[i].drd);
      chk($sformatf("v%0d_derr", i),  dmem_error, tbl[i].de);
    end

    // Saturation: both ports re-issue on every ready; 20 grants strictly alternating I, D.
    do_reset();
    ni = 0;
    nd = 0;
    for (int k = 0; k < 23; k++) begin
      @(posedge clock); #1;
      imem_valid = (k == 0) || (imem_ready && k <= 18);
      imem_addr  = 32'h14;
      dmem_valid = (k == 0) || (dmem_ready && k <= 18);
      dmem_addr  = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
      @(negedge clock);
      chk($sformatf("sat%0d_irdy", k), imem_ready, (k >= 1 && k <= 20 && (k % 2) == 1));
      chk($sformatf("sat%0d_drdy", k), dmem_ready, (k >= 1 && k <= 20 && (k % 2) == 0));
      chk($sformatf("sat%0d_en", k),   bram_en,    (k <= 19));
      if (imem_ready) ni++;
      if (dmem_ready) nd++;
    end
    chk("sat_icount", ni, 10);
    chk("sat_dcount", nd, 10);

    // Reset the cycle after a conflict: the pending data request is dropped.
    @(posedge clock); #1;
    imem_valid = 1'b1; imem_addr = 32'h14;
    dmem_valid = 1'b1; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    @(negedge clock);
    chk("mid_en",    bram_en,   1);
    chk("mid_baddr", bram_addr, 11'h5);
    @(posedge clock); #1;
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_irdy",  imem_ready, 1);
    chk("mid_drdy",  dmem_ready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk_zero("midrst");
    @(posedge clock); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("post%0d_drdy", k), dmem_ready, 0);
      chk($sformatf("post%0d_en", k),   bram_en,    0);
      @(posedge clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
